// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand/result handshake and 4-bit adder-slice bus for nibble_serial_add_ctrl.
// The slave side is the controller; the master side is the operand source plus the slice.
interface nibble_serial_add_ctrl_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic             op_sub;
   logic             op_signed;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       add_a;
   logic [3:0]       add_b;
   logic             add_cin;
   logic [3:0]       add_sum;
   logic             add_cout;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             overflow;
   logic             zero;

   modport master (
      output start, op_sub, op_signed, a, b, add_sum, add_cout,
      input  add_a, add_b, add_cin, busy, done, result, cout, overflow, zero
   );

   modport slave (
      input  start, op_sub, op_signed, a, b, add_sum, add_cout,
      output add_a, add_b, add_cin, busy, done, result, cout, overflow, zero
   );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Drives an external 4-bit adder slice one nibble per clock, LSB first, to add or
// subtract two WIDTH-bit operands; reports carry, signed overflow and zero on done.
module nibble_serial_add_ctrl #(
   parameter int WIDTH = 16
) (
   input logic                    clk,
   input logic                    rst_n,
   nibble_serial_add_ctrl_if.slave bus
);
   localparam int NIB = WIDTH / 4;
   localparam int KW  = (NIB > 2) ? $clog2(NIB) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);
   localparam logic [KW-1:0] K_ONE  = KW'(1);
   localparam logic [KW-1:0] K_ZERO = KW'(0);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q,  state_d;
   logic [KW-1:0]    k_q,      k_d;
   logic             carry_q,  carry_d;
   logic             sgn_q,    sgn_d;
   logic [WIDTH-1:0] a_q,      a_d;
   logic [WIDTH-1:0] b_q,      b_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             cout_q,   cout_d;
   logic             ovf_q,    ovf_d;
   logic             zero_q,   zero_d;

   // Two's-complement overflow from the operand and sum sign bits.
   function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      signed_ovf = (a_msb & b_msb & ~s_msb) | (~a_msb & ~b_msb & s_msb);
   endfunction

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      carry_d  = carry_q;
      sgn_d    = sgn_q;
      a_d      = a_q;
      b_d      = b_q;
      shadow_d = shadow_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.op_sub ? ~bus.b : bus.b;
               sgn_d   = bus.op_signed;
               k_d     = K_ZERO;
               carry_d = bus.op_sub;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            shadow_d[{k_q, 2'b00} +: 4] = bus.add_sum;
            carry_d = bus.add_cout;
            if (k_q == K_LAST) begin
               k_d      = K_ZERO;
               state_d  = S_DONE;
               result_d = shadow_d;
               cout_d   = bus.add_cout;
               ovf_d    = sgn_q & signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1], bus.add_sum[3]);
               zero_d   = (shadow_d == {WIDTH{1'b0}});
            end else begin
               k_d     = k_q + K_ONE;
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         k_q      <= K_ZERO;
         carry_q  <= 1'b0;
         sgn_q    <= 1'b0;
         a_q      <= {WIDTH{1'b0}};
         b_q      <= {WIDTH{1'b0}};
         shadow_q <= {WIDTH{1'b0}};
         result_q <= {WIDTH{1'b0}};
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         carry_q  <= carry_d;
         sgn_q    <= sgn_d;
         a_q      <= a_d;
         b_q      <= b_d;
         shadow_q <= shadow_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
      end
   end

   // Slice inputs are only live in RUN so the slice sees a quiet bus otherwise.
   assign bus.add_a    = (state_q == S_RUN) ? a_q[{k_q, 2'b00} +: 4] : 4'h0;
   assign bus.add_b    = (state_q == S_RUN) ? b_q[{k_q, 2'b00} +: 4] : 4'h0;
   assign bus.add_cin  = (state_q == S_RUN) ? carry_q : 1'b0;
   assign bus.busy     = (state_q == S_RUN);
   assign bus.done     = (state_q == S_DONE);
   assign bus.result   = result_q;
   assign bus.cout     = cout_q;
   assign bus.overflow = ovf_q;
   assign bus.zero     = zero_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl (WIDTH=16) with a behavioural 4-bit adder slice.
module tb_nibble_serial_add_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   nibble_serial_add_ctrl_if #(.WIDTH(16)) bif ();

   nibble_serial_add_ctrl #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   logic [4:0] slice_sum;
   assign slice_sum    = {1'b0, bif.add_a} + {1'b0, bif.add_b} + {4'b0000, bif.add_cin};
   assign bif.add_sum  = slice_sum[3:0];
   assign bif.add_cout = slice_sum[4];

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Launch one operation and watch it for 12 cycles; no checking here.
   task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts, input logic tsg,
                        output logic [15:0] r, output logic co, output logic ov, output logic zr,
                        output int bc, output int dc, output int dat, output logic [3:0] cins);
      bif.a = ta; bif.b = tb_v; bif.op_sub = ts; bif.op_signed = tsg; bif.start = 1'b1;
      step();
      bif.start = 1'b0;
      r = 16'h0; co = 1'b0; ov = 1'b0; zr = 1'b0;
      bc = 0; dc = 0; dat = -1; cins = 4'h0;
      for (int i = 0; i < 12; i++) begin
         if (bif.busy) begin
            if (bc < 4) cins[bc] = bif.add_cin;
            bc++;
         end
         if (bif.done) begin
            dc++;
            if (dat < 0) dat = i;
            r = bif.result; co = bif.cout; ov = bif.overflow; zr = bif.zero;
         end
         step();
      end
   endtask

   task automatic test_reset();
      bif.start = 1'b0; bif.op_sub = 1'b0; bif.op_signed = 1'b0; bif.a = 16'h0; bif.b = 16'h0;
      rst_n = 1'b0;
      step(); step();
      total++;
      if ({bif.busy, bif.done, bif.cout, bif.overflow, bif.zero} !== 5'b00000) begin
         bad++; $display("FAIL reset_flags got=%b exp=00000", {bif.busy, bif.done, bif.cout, bif.overflow, bif.zero});
      end
      total++;
      if (bif.result !== 16'h0000) begin bad++; $display("FAIL reset_result got=%h exp=0000", bif.result); end
      total++;
      if ({bif.add_a, bif.add_b, bif.add_cin} !== 9'h000) begin
         bad++; $display("FAIL reset_slice got=%h exp=000", {bif.add_a, bif.add_b, bif.add_cin});
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_add_unsigned();
      logic [15:0] r; logic co, ov, zr; int bc, dc, dat; logic [3:0] cins;
      do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, r, co, ov, zr, bc, dc, dat, cins);
      total++;
      if (r !== 16'h2233) begin bad++; $display("FAIL add_u_result got=%h exp=2233", r); end
      total++;
      if ({co, ov, zr} !== 3'b000) begin bad++; $display("FAIL add_u_flags got=%b exp=000", {co, ov, zr}); end
      total++;
      if (bc !== 4) begin bad++; $display("FAIL add_u_busy_cycles got=%0d exp=4", bc); end
      total++;
      if (dc !== 1) begin bad++; $display("FAIL add_u_done_pulses got=%0d exp=1", dc); end
      total++;
      if (dat !== 4) begin bad++; $display("FAIL add_u_latency got=%0d exp=4", dat); end
      total++;
      if (bif.result !== 16'h2233) begin bad++; $display("FAIL add_u_hold got=%h exp=2233", bif.result); end
   endtask

   task automatic test_add_signed();
      logic [15:0] r; logic co, ov, zr; int bc, dc, dat; logic [3:0] cins;
      do_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, r, co, ov, zr, bc, dc, dat, cins);
      total++;
      if (r !== 16'h8000) begin bad++; $display("FAIL add_s_result got=%h exp=8000", r); end
      total++;
      if ({co, ov, zr} !== 3'b010) begin bad++; $display("FAIL add_s_flags got=%b exp=010", {co, ov, zr}); end
      do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, r, co, ov, zr, bc, dc, dat, cins);
      total++;
      if ({co, ov, zr} !== 3'b000) begin bad++; $display("FAIL add_us_flags got=%b exp=000", {co, ov, zr}); end
   endtask

   task automatic test_carry_chain();
      logic [15:0] r; logic co, ov, zr; int bc, dc, dat; logic [3:0] cins;
      do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, r, co, ov, zr, bc, dc, dat, cins);
      total++;
      if (r !== 16'h0000) begin bad++; $display("FAIL carry_result got=%h exp=0000", r); end
      total++;
      if ({co, ov, zr} !== 3'b101) begin bad++; $display("FAIL carry_flags got=%b exp=101", {co, ov, zr}); end
      total++;
      if (cins !== 4'b1110) begin bad++; $display("FAIL carry_cin_seq got=%b exp=1110", cins); end
   endtask

   task automatic test_subtract();
      logic [15:0] r; logic co, ov, zr; int bc, dc, dat; logic [3:0] cins;
      do_op(16'h0005, 16'h0007, 1'b1, 1'b1, r, co, ov, zr, bc, dc, dat, cins);
      total++;
      if (r !== 16'hFFFE) begin bad++; $display("FAIL sub1_result got=%h exp=fffe", r); end
      total++;
      if ({co, ov, zr} !== 3'b000) begin bad++; $display("FAIL sub1_flags got=%b exp=000", {co, ov, zr}); end
      total++;
      if (cins !== 4'b0001) begin bad++; $display("FAIL sub1_cin_seq got=%b exp=0001", cins); end
      do_op(16'h8000, 16'h0001, 1'b1, 1'b1, r, co, ov, zr, bc, dc, dat, cins);
      total++;
      if (r !== 16'h7FFF) begin bad++; $display("FAIL sub2_result got=%h exp=7fff", r); end
      total++;
      if ({co, ov, zr} !== 3'b110) begin bad++; $display("FAIL sub2_flags got=%b exp=110", {co, ov, zr}); end
   endtask

   task automatic test_start_in_run();
      int dc; logic [15:0] r;
      bif.a = 16'h1111; bif.b = 16'h2222; bif.op_sub = 1'b0; bif.op_signed = 1'b0; bif.start = 1'b1;
      step();
      bif.start = 1'b0;
      step(); step();
      bif.a = 16'hAAAA; bif.b = 16'h5555; bif.op_sub = 1'b1; bif.start = 1'b1;
      step();
      bif.start = 1'b0;
      dc = 0; r = 16'h0;
      for (int i = 0; i < 8; i++) begin
         if (bif.done) begin dc++; r = bif.result; end
         step();
      end
      total++;
      if (dc !== 1) begin bad++; $display("FAIL run_start_done_pulses got=%0d exp=1", dc); end
      total++;
      if (r !== 16'h3333) begin bad++; $display("FAIL run_start_result got=%h exp=3333", r); end
      total++;
      if (bif.busy !== 1'b0) begin bad++; $display("FAIL run_start_busy got=%b exp=0", bif.busy); end
   endtask

   task automatic test_back_to_back();
      bif.a = 16'h0001; bif.b = 16'h0002; bif.op_sub = 1'b0; bif.op_signed = 1'b0; bif.start = 1'b1;
      step();
      bif.a = 16'h00F0; bif.b = 16'h0F00;
      for (int i = 0; i < 4; i++) step();
      total++;
      if ({bif.done, bif.result} !== {1'b1, 16'h0003}) begin
         bad++; $display("FAIL b2b_first got=%b/%h exp=1/0003", bif.done, bif.result);
      end
      step();
      bif.start = 1'b0;
      total++;
      if ({bif.busy, bif.done} !== 2'b10) begin bad++; $display("FAIL b2b_no_gap got=%b exp=10", {bif.busy, bif.done}); end
      for (int i = 0; i < 4; i++) step();
      total++;
      if ({bif.done, bif.result} !== {1'b1, 16'h0FF0}) begin
         bad++; $display("FAIL b2b_second got=%b/%h exp=1/0ff0", bif.done, bif.result);
      end
      step();
   endtask

   task automatic test_reset_abort();
      logic [15:0] r; logic co, ov, zr; int bc, dc, dat; logic [3:0] cins;
      int dcnt;
      bif.a = 16'h1234; bif.b = 16'h1111; bif.op_sub = 1'b0; bif.op_signed = 1'b0; bif.start = 1'b1;
      step();
      bif.start = 1'b0;
      step(); step();
      rst_n = 1'b0;
      step();
      total++;
      if ({bif.busy, bif.done, bif.cout, bif.overflow, bif.zero, bif.result} !== 21'h0) begin
         bad++; $display("FAIL abort_outputs got=%b%b%b%b%b/%h exp=00000/0000",
                         bif.busy, bif.done, bif.cout, bif.overflow, bif.zero, bif.result);
      end
      rst_n = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (bif.done || bif.busy) dcnt++;
         step();
      end
      total++;
      if (dcnt !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", dcnt); end
      do_op(16'h0100, 16'h0200, 1'b0, 1'b0, r, co, ov, zr, bc, dc, dat, cins);
      total++;
      if (r !== 16'h0300 || dc !== 1) begin bad++; $display("FAIL abort_recover got=%h/%0d exp=0300/1", r, dc); end
   endtask

   initial begin
      test_reset();
      test_add_unsigned();
      test_add_signed();
      test_carry_chain();
      test_subtract();
      test_start_in_run();
      test_back_to_back();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
